// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : traffic_pkg                                                  |
// | Description : Shared definitions for the farm-road traffic controller:     |
// |               walk-request FSM state encodings and timebase constants.     |
// | Contents    : wrState_t  - walk request FSM states                         |
// |               CLK_HZ     - system clock frequency                          |
// |               DEBOUNCE_MS- nominal button debounce window                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package traffic_pkg;

   typedef enum logic [1:0] {
      WR_IDLE    = 2'b00,
      WR_PENDING = 2'b01,
      WR_LOCKOUT = 2'b10
   } wrState_t;

   localparam int CLK_HZ      = 50_000_000;
   localparam int DEBOUNCE_MS = 20;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/walk_request_conditioner_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : walk_request_conditioner_if                                  |
// | Description : Walk request handshake between the button conditioner       |
// |               (requester) and the traffic-light FSM (server).             |
// | Signals     : req      - walk request pending (level)                     |
// |               req_ack  - one-cycle acknowledge from the traffic FSM       |
// |               wait_led - WAIT indicator, mirrors req                      |
// | Modports    : master - conditioner side, slave - traffic FSM side         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface walk_request_conditioner_if;

   logic req;
   logic req_ack;
   logic wait_led;

   modport master (
      output req,
      output wait_led,
      input  req_ack
   );

   modport slave (
      input  req,
      input  wait_led,
      output req_ack
   );

endinterface : walk_request_conditioner_if
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_debounce                                                 |
// | Description : Synchroniser, debounce counter and press-edge detector for   |
// |               an asynchronous, bouncy, active-low push button.             |
// | Ports       : clk         in  system clock                                 |
// |               rst_n       in  asynchronous active-low reset                |
// |               btn_n_raw   in  raw button, active-low                       |
// |               btn_level   out debounced button, 1 = pressed                |
// |               press_pulse out one-cycle pulse on each accepted press       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module btn_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  wire  clk,
   input  wire  rst_n,
   input  wire  btn_n_raw,
   output logic btn_level,
   output logic press_pulse
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_level;
   logic                   r_pulse;
   logic                   w_sample;

   // Synchronised sample converted to active-high so it compares directly
   // against the debounced level.
   assign w_sample = ~r_sync[SYNC_STAGES-1];

   // Flops reset to '1' so a released button is seen during and after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], btn_n_raw};
      end
   end

   // The counter measures how long the sample has continuously disagreed
   // with the accepted level; any agreement restarts the measurement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         if (w_sample != r_level) begin
            if (r_cnt == c_CNT_MAX) begin
               r_level <= w_sample;
               r_cnt   <= '0;
               // Only the released->pressed flip produces a pulse.
               r_pulse <= w_sample;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign btn_level   = r_level;
   assign press_pulse = r_pulse;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/walk_request_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : walk_request_conditioner                                     |
// | Description : Farm-road walkers button front end. Debounces the raw        |
// |               button, latches a single walk request until the traffic FSM |
// |               acknowledges it, then ignores presses for a lockout window  |
// |               counted in tick_1s pulses.                                  |
// | Ports       : clk         in  system clock, 50 MHz                         |
// |               rst_n       in  asynchronous active-low reset                |
// |               btn_n_raw   in  raw walkers button, active-low               |
// |               tick_1s     in  one-cycle pulse per second                   |
// |               press_pulse out one-cycle pulse per accepted press           |
// |               btn_level   out debounced button, 1 = pressed                |
// |               reqBus      if  req / req_ack / wait_led handshake (master)  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module walk_request_conditioner
   import traffic_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS,
   parameter int CNT_W           = 20,
   parameter int LOCKOUT_SECS    = 5,
   parameter int LOCK_W          = 4
) (
   input  wire                         clk,
   input  wire                         rst_n,
   input  wire                         btn_n_raw,
   input  wire                         tick_1s,
   output logic                        press_pulse,
   output logic                        btn_level,
   walk_request_conditioner_if.master  reqBus
);

   localparam logic [LOCK_W-1:0] c_LOCK_INIT = LOCK_W'(LOCKOUT_SECS);
   localparam logic [LOCK_W-1:0] c_LOCK_ONE  = LOCK_W'(1);

   wrState_t          r_state;
   logic [LOCK_W-1:0] r_lockCnt;
   logic              r_req;

   btn_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_btnDebounce (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_n_raw   (btn_n_raw),
      .btn_level   (btn_level),
      .press_pulse (press_pulse)
   );

   // Request/lockout FSM. req is registered alongside the state so it
   // follows press_pulse by one cycle and drops the cycle after req_ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= WR_IDLE;
         r_lockCnt <= '0;
         r_req     <= 1'b0;
      end else begin
         case (r_state)
            WR_IDLE: begin
               if (press_pulse) begin
                  r_state <= WR_PENDING;
                  r_req   <= 1'b1;
               end
            end
            WR_PENDING: begin
               // Acknowledge takes priority; a simultaneous press is dropped
               // and any tick in this cycle is not part of the new lockout.
               if (reqBus.req_ack) begin
                  r_req <= 1'b0;
                  if (LOCKOUT_SECS == 0) begin
                     r_state <= WR_IDLE;
                  end else begin
                     r_state   <= WR_LOCKOUT;
                     r_lockCnt <= c_LOCK_INIT;
                  end
               end
            end
            WR_LOCKOUT: begin
               // Presses are discarded here, including one on the expiry
               // cycle, since the FSM only listens to presses in IDLE.
               if (r_lockCnt == '0) begin
                  r_state <= WR_IDLE;
               end else if (tick_1s) begin
                  r_lockCnt <= r_lockCnt - 1'b1;
                  if (r_lockCnt == c_LOCK_ONE) begin
                     r_state <= WR_IDLE;
                  end
               end
            end
            default: begin
               r_state   <= WR_IDLE;
               r_lockCnt <= '0;
               r_req     <= 1'b0;
            end
         endcase
      end
   end

   assign reqBus.req      = r_req;
   assign reqBus.wait_led = r_req;

endmodule : walk_request_conditioner
`default_nettype wire

// File: tb/tb_walk_request_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_walk_request_conditioner                                  |
// | Description : Self-checking bench for walk_request_conditioner with a      |
// |               behavioural reference model (sample history + request       |
// |               bookkeeping) and scenario tasks plus a random soak.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_walk_request_conditioner;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int LOCK = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic btnNRaw = 1'b1;
   logic tick1s = 1'b0;
   logic pressPulse;
   logic btnLevel;

   walk_request_conditioner_if ifc();

   int total = 0;
   int bad   = 0;

   walk_request_conditioner #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (3),
      .LOCKOUT_SECS    (LOCK),
      .LOCK_W          (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_n_raw   (btnNRaw),
      .tick_1s     (tick1s),
      .press_pulse (pressPulse),
      .btn_level   (btnLevel),
      .reqBus      (ifc)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Button: raw samples travel through a SYNC-deep delay line; the debounced
   // level flips once the last DEB delayed samples all disagree with it.
   // Request: a pending flag plus a remaining-seconds number.
   bit syncQ[$];
   bit pressedQ[$];
   bit mLevel, mPulse, mPending, mLocked, usedRaw, flip;
   int mLockLeft;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncQ.delete();
         for (int i = 0; i < SYNC; i++) syncQ.push_back(1'b1);
         pressedQ.delete();
         mLevel = 0; mPulse = 0; mPending = 0; mLocked = 0; mLockLeft = 0;
      end else begin
         if (mPending) begin
            if (ifc.req_ack) begin
               mPending = 0;
               if (LOCK > 0) begin mLocked = 1; mLockLeft = LOCK; end
            end
         end else if (mLocked) begin
            if (tick1s) begin
               mLockLeft = mLockLeft - 1;
               if (mLockLeft == 0) mLocked = 0;
            end
         end else if (mPulse) begin
            mPending = 1;
         end
         usedRaw = syncQ.pop_front();
         syncQ.push_back(btnNRaw);
         pressedQ.push_back(!usedRaw);
         if (pressedQ.size() > DEB) void'(pressedQ.pop_front());
         flip = 0;
         if (pressedQ.size() == DEB) begin
            flip = 1;
            foreach (pressedQ[i]) if (pressedQ[i] == mLevel) flip = 0;
         end
         mPulse = 0;
         if (flip) begin
            mLevel = !mLevel;
            mPulse = mLevel;
            pressedQ.delete();
         end
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      btnNRaw = 1; tick1s = 0; ifc.req_ack = 0;
      #2 rst_n = 0;
      #1;
      total++;
      if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== 4'b0000) begin
         bad++; $display("FAIL reset_async got=%b want=0000", {btnLevel, pressPulse, ifc.req, ifc.wait_led});
      end
      repeat (3) @(negedge clk);
      total++;
      if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
         bad++; $display("FAIL reset_hold got=%b want=%b", {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
      end
      rst_n = 1;
   endtask

   task automatic test_bounce();
      bit sawAny = 0;
      int lowLeft = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL bounce cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         sawAny = sawAny | btnLevel | pressPulse | ifc.req;
         if (c < 20) begin
            btnNRaw = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
         end else if (c < 50) begin
            // random glitches shorter than the debounce window
            if (lowLeft > 0) begin
               lowLeft--; btnNRaw = 0;
            end else if (btnNRaw == 0) begin
               btnNRaw = 1;
            end else if ($urandom_range(0, 2) == 0) begin
               lowLeft = $urandom_range(0, DEB - 2); btnNRaw = 0;
            end
         end else begin
            btnNRaw = 1;
         end
      end
      total++;
      if (sawAny !== 1'b0) begin
         bad++; $display("FAIL bounce_quiet got=%b want=0", sawAny);
      end
   endtask

   task automatic test_clean_press();
      int lat = 0;
      bit seen = 0;
      btnNRaw = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         lat++;
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL clean cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         if (pressPulse === 1'b1) seen = 1;
      end
      total++;
      if (!seen || lat != SYNC + DEB) begin
         bad++; $display("FAIL clean_latency got=%0d want=%0d", lat, SYNC + DEB);
      end
      @(negedge clk);
      total++;
      if ({pressPulse, ifc.req, ifc.wait_led} !== 3'b011) begin
         bad++; $display("FAIL clean_req got=%b want=011", {pressPulse, ifc.req, ifc.wait_led});
      end
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL clean_tail cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         btnNRaw = (c < 3) ? 1'b0 : 1'b1;
      end
   endtask

   task automatic test_ack_lockout();
      int t1, t2, t3;
      bit sawReq = 0;
      ifc.req_ack = 1;
      @(negedge clk);
      ifc.req_ack = 0;
      total++;
      if (ifc.req !== 1'b0) begin
         bad++; $display("FAIL ack_clear got=%b want=0", ifc.req);
      end
      t1 = $urandom_range(14, 18);
      t2 = t1 + $urandom_range(5, 12);
      t3 = t2 + $urandom_range(5, 12);
      for (int c = 0; c <= t3 + 3; c++) begin
         @(negedge clk);
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL lockout cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         sawReq = sawReq | ifc.req;
         tick1s = (c == t1 || c == t2 || c == t3);
         btnNRaw = (c >= 1 && c < 11) ? 1'b0 : 1'b1;
      end
      total++;
      if (sawReq !== 1'b0) begin
         bad++; $display("FAIL lockout_press_ignored got=%b want=0", sawReq);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL relock cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         btnNRaw = (c < 8) ? 1'b0 : 1'b1;
      end
      total++;
      if (ifc.req !== 1'b1) begin
         bad++; $display("FAIL press_after_lockout got=%b want=1", ifc.req);
      end
   endtask

   task automatic test_same_cycle();
      bit found = 0;
      bit sawReq = 0;
      // re-press while pending; ack and tick land on the press_pulse cycle
      btnNRaw = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL same_cycle cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         if (mPulse) begin ifc.req_ack = 1; tick1s = 1; found = 1; end
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL same_cycle_timeout got=0 want=1");
      end
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL same_lock cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         sawReq = sawReq | ifc.req;
         ifc.req_ack = 0;
         tick1s = (c == 10 || c == 16);
         btnNRaw = (c < 4) ? 1'b0 : 1'b1;
      end
      // press arriving on the cycle of the final tick must be dropped
      found = 0;
      btnNRaw = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL expiry cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         sawReq = sawReq | ifc.req;
         if (mPulse) begin tick1s = 1; found = 1; end
      end
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL expiry_tail cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         sawReq = sawReq | ifc.req;
         tick1s = 0;
         btnNRaw = (c < 3) ? 1'b0 : 1'b1;
      end
      total++;
      if (sawReq !== 1'b0 || !found) begin
         bad++; $display("FAIL expiry_press_dropped got=%b want=0 found=%b", sawReq, found);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL after_expiry cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         btnNRaw = (c < 8) ? 1'b0 : 1'b1;
      end
      total++;
      if (ifc.req !== 1'b1) begin
         bad++; $display("FAIL press_after_expiry got=%b want=1", ifc.req);
      end
   endtask

   task automatic test_held();
      int pulses = 0;
      bit sawReq = 0;
      ifc.req_ack = 1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL held_pre cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         ifc.req_ack = 0;
         tick1s = (c == 3 || c == 6 || c == 9);
      end
      for (int c = 0; c < 125; c++) begin
         @(negedge clk);
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL held cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         if (pressPulse === 1'b1) pulses++;
         if (c > 62) sawReq = sawReq | ifc.req;
         ifc.req_ack = (c == 60);
         tick1s = (c == 70 || c == 80 || c == 90);
         btnNRaw = (c < 100) ? 1'b0 : 1'b1;
      end
      total++;
      if (pulses != 1) begin
         bad++; $display("FAIL held_one_pulse got=%0d want=1", pulses);
      end
      total++;
      if (sawReq !== 1'b0) begin
         bad++; $display("FAIL held_no_spurious got=%b want=0", sawReq);
      end
   endtask

   task automatic test_reset_mid_lockout();
      bit got = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL rst_setup cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         btnNRaw = (c < 8) ? 1'b0 : 1'b1;
         ifc.req_ack = (c == 17);
         tick1s = (c == 21);
      end
      @(negedge clk);
      tick1s = 0;
      btnNRaw = 0;
      #2 rst_n = 0;
      #1;
      total++;
      if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== 4'b0000) begin
         bad++; $display("FAIL reset_mid_lockout got=%b want=0000", {btnLevel, pressPulse, ifc.req, ifc.wait_led});
      end
      btnNRaw = 1;
      @(negedge clk);
      rst_n = 1;
      btnNRaw = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL rst_repress cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         if (ifc.req === 1'b1) got = 1;
      end
      total++;
      if (!got) begin
         bad++; $display("FAIL req_after_reset got=0 want=1");
      end
      btnNRaw = 1;
   endtask

   task automatic test_random();
      int runLeft = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         total++;
         if ({btnLevel, pressPulse, ifc.req, ifc.wait_led} !== {mLevel, mPulse, mPending, mPending}) begin
            bad++; $display("FAIL random cyc=%0d got=%b want=%b", c, {btnLevel, pressPulse, ifc.req, ifc.wait_led}, {mLevel, mPulse, mPending, mPending});
         end
         if (runLeft == 0) begin
            btnNRaw = ($urandom_range(0, 1) == 1);
            runLeft = $urandom_range(1, 12);
         end else begin
            runLeft--;
         end
         tick1s = ($urandom_range(0, 15) == 0);
         ifc.req_ack = ($urandom_range(0, 7) == 0);
      end
      tick1s = 0;
      ifc.req_ack = 0;
   endtask

   initial begin
      ifc.req_ack = 0;
      test_reset();
      test_bounce();
      test_clean_press();
      test_ack_lockout();
      test_same_cycle();
      test_held();
      test_reset_mid_lockout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_walk_request_conditioner
`default_nettype wire
